// File: rtl/tcdm_sram_responder.sv
// tcdm_sram_responder: TCDM request/grant responder in front of a single-port SRAM.
// Grant FSM with programmable wait states and an external hold, a response
// pipeline matched to the SRAM read latency, and optional out-of-range errors.
// Optional feature macro: TCDM_RESP_ERR_EN (range check and r_opc_o error responses).
module tcdm_sram_responder #(
    parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000,
    parameter int          MEM_ADDR_WIDTH = 14,
    parameter int          MEM_LATENCY    = 1,
    parameter int          WAIT_STATES    = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic [31:0]               add_i,
    input  logic                      wen_i,
    input  logic [31:0]               wdata_i,
    input  logic [3:0]                be_i,
    output logic                      gnt_o,
    output logic                      r_valid_o,
    output logic [31:0]               r_rdata_o,
    output logic                      r_opc_o,
    input  logic                      hold_i,
    output logic                      mem_csn_o,
    output logic                      mem_wen_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]               mem_wdata_o,
    output logic [3:0]                mem_be_o,
    input  logic [31:0]               mem_rdata_i
);

    localparam logic [32:0] BANK_BYTES = 33'd1 << (MEM_ADDR_WIDTH + 2);
    localparam int          LAST       = MEM_LATENCY - 1;

    if (MEM_LATENCY < 1 || MEM_LATENCY > 3) begin : g_bad_latency
        $error("MEM_LATENCY out of range 1..3");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait
        $error("WAIT_STATES out of range 0..7");
    end
    if (MEM_ADDR_WIDTH < 1 || MEM_ADDR_WIDTH > 30) begin : g_bad_aw
        $error("MEM_ADDR_WIDTH out of range 1..30");
    end

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       gnt;

    logic [MEM_LATENCY-1:0] vld_q, vld_d;
    logic [MEM_LATENCY-1:0] err_q, err_d;
    logic [MEM_LATENCY-1:0] rd_q, rd_d;

    logic [31:0] off;
    logic        in_range;
    logic        access;
    logic        unused_off;

    // Address decode: offset from the bank base in wrap-around arithmetic.
    assign off        = add_i - BASE_ADDR;
    assign unused_off = ^off;
`ifdef TCDM_RESP_ERR_EN
    assign in_range   = ({1'b0, off} < BANK_BYTES);
`else
    assign in_range   = 1'b1;
`endif

    // Grant FSM next state: wait-state countdown, frozen while held, abandoned if req drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_i && !hold_i) begin
                    if (WAIT_STATES == 0) begin
                        gnt = 1'b1;
                    end else begin
                        cnt_d   = 3'(WAIT_STATES - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else if (!hold_i) begin
                    if (cnt_q == 3'd0) begin
                        gnt     = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grant and SRAM strobes are combinational; reset forces them inactive.
    assign gnt_o       = gnt & ~rst_i;
    assign access      = gnt_o & in_range;
    assign mem_csn_o   = ~access;
    assign mem_wen_o   = access ? wen_i : 1'b1;
    assign mem_addr_o  = access ? off[MEM_ADDR_WIDTH+1:2] : '0;
    assign mem_wdata_o = access ? wdata_i : 32'd0;
    assign mem_be_o    = access ? be_i : 4'd0;

    // Response pipeline shift: stage 0 captures the grant, later stages age it.
    always_comb begin
        vld_d    = vld_q;
        err_d    = err_q;
        rd_d     = rd_q;
        vld_d[0] = gnt_o;
        err_d[0] = gnt_o & ~in_range;
        rd_d[0]  = wen_i;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            rd_d[i]  = rd_q[i-1];
        end
    end

    // State, counter and pipeline registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            vld_q   <= '0;
            err_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    // Last stage drives the response; data only for good reads.
    assign r_valid_o = vld_q[LAST] & ~rst_i;
`ifdef TCDM_RESP_ERR_EN
    assign r_opc_o   = vld_q[LAST] & err_q[LAST] & ~rst_i;
`else
    assign r_opc_o   = 1'b0;
`endif
    assign r_rdata_o = (r_valid_o && !err_q[LAST] && rd_q[LAST]) ? mem_rdata_i : 32'd0;

    // A hold must always win over a grant.
    assert property (@(posedge clk_i) disable iff (rst_i) !(gnt_o && hold_i))
        else $error("grant issued while hold_i high");

endmodule
